// File: rtl/hex_scroll_ctrl_if.sv
// Nibble write channel into the scrolling hex display controller.
// Valid/ready handshake; wr_last marks the final nibble of a message.
interface hex_scroll_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_data;
    logic       wr_last;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a buffered hex message across six seven-segment digits.
// Optional HEX_SCROLL_BLINK_EN: blink the frozen frame while paused.
module hex_scroll_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int DEPTH    = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    hex_scroll_ctrl_if.slave         wr,
    input  logic                     pause,
    input  logic                     stop,
    output logic [6:0]               HEX0,
    output logic [6:0]               HEX1,
    output logic [6:0]               HEX2,
    output logic [6:0]               HEX3,
    output logic [6:0]               HEX4,
    output logic [6:0]               HEX5,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   msg_len
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SCROLL = 2'd2,
        PAUSED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] off_q;
    logic [AW-1:0] off_nxt;
    logic [CW-1:0] cnt_q;
    logic [AW:0]   len_q;
    logic [3:0]    mem [DEPTH];
    logic [6:0]    hex_q [6];
    logic [6:0]    seg_d [6];
    logic [AW:0]   idx [6];
    logic          xfer, commit, tick, show;
    logic          blank_q;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign wr.wr_ready = (state_q == IDLE) || (state_q == LOAD);
    assign xfer   = wr.wr_valid && wr.wr_ready && !stop;
    assign commit = xfer && (wr.wr_last ||
                    (state_q == LOAD && wr_ptr_q == AW'(DEPTH - 1)));
    assign tick   = cnt_q == CW'(TICK_DIV - 1);
    assign off_nxt = ({1'b0, off_q} + (AW+1)'(1) == len_q) ?
                     '0 : off_q + AW'(1);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, LOAD: begin
                    if (commit)    state_d = SCROLL;
                    else if (xfer) state_d = LOAD;
                end
                SCROLL: if (pause)  state_d = PAUSED;
                PAUSED: if (!pause) state_d = SCROLL;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
`ifdef HEX_SCROLL_BLINK_EN
            blank_q  <= 1'b0;
`endif
        end else if (stop) begin
            wr_ptr_q <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
`ifdef HEX_SCROLL_BLINK_EN
            blank_q  <= 1'b0;
`endif
        end else begin
            if (xfer) wr_ptr_q <= commit ? '0 : wr_ptr_q + AW'(1);
            if (commit) begin
                len_q <= {1'b0, wr_ptr_q} + (AW+1)'(1);
                off_q <= '0;
                cnt_q <= '0;
            end
            case (state_q)
                SCROLL: begin
`ifdef HEX_SCROLL_BLINK_EN
                    blank_q <= 1'b0;
`endif
                    if (!pause) begin
                        cnt_q <= tick ? '0 : cnt_q + CW'(1);
                        if (tick) off_q <= off_nxt;
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        cnt_q <= '0;
`ifdef HEX_SCROLL_BLINK_EN
                        blank_q <= 1'b0;
                    end else begin
                        cnt_q <= tick ? '0 : cnt_q + CW'(1);
                        if (tick) blank_q <= ~blank_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef HEX_SCROLL_BLINK_EN
    assign blank_q = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (xfer) mem[wr_ptr_q] <= wr.wr_data;
    end

    // Digit k shows buffer[(offset+5-k) mod L]; offset < L so at most 5 folds
    always_comb begin
        idx   = '{default: '0};
        seg_d = '{default: 7'h7F};
        for (int k = 0; k < 6; k++) begin
            idx[k] = {1'b0, off_q} + (AW+1)'(5 - k);
            for (int j = 0; j < 5; j++) begin
                if (idx[k] >= len_q) idx[k] = idx[k] - len_q;
            end
            seg_d[k] = seg7(mem[idx[k][AW-1:0]]);
        end
    end

    assign show = (state_q == SCROLL || state_q == PAUSED) && !blank_q;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < 6; k++) hex_q[k] <= 7'h7F;
        end else begin
            for (int k = 0; k < 6; k++) hex_q[k] <= show ? seg_d[k] : 7'h7F;
        end
    end

    assign HEX0    = hex_q[0];
    assign HEX1    = hex_q[1];
    assign HEX2    = hex_q[2];
    assign HEX3    = hex_q[3];
    assign HEX4    = hex_q[4];
    assign HEX5    = hex_q[5];
    assign state   = state_q;
    assign msg_len = len_q;
endmodule

// File: doc/hex_scroll_ctrl.md
HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000, meaning CLOCK_50 cycles per scroll step (0.5 s); legal range 2..2^26.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning message buffer capacity in nibbles; power of two, 8..64.
REQ-003 CLOCK_50  input  1  50 MHz clock; all state rises on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 wr_valid  input  1  nibble write request.
REQ-006 wr_ready  output  1  block accepts a nibble this cycle.
REQ-007 wr_data  input  4  hex nibble to append to the message.
REQ-008 wr_last  input  1  qualifies wr_data as the final nibble; commits the message.
REQ-009 pause  input  1  level; freezes scrolling while high.
REQ-010 stop  input  1  one-cycle pulse; aborts and clears the message.
REQ-011 HEX0..HEX5  output  7 each  active-low segments {g,f,e,d,c,b,a}; HEX5 is leftmost.
REQ-012 state  output  2  current state: IDLE=0, LOAD=1, SCROLL=2, PAUSED=3.
REQ-013 msg_len  output  log2(DEPTH)+1  committed message length L; 0 when none.

Function
REQ-014 A transfer SHALL occur when wr_valid and wr_ready are both high on a rising edge; wr_ready SHALL be high only in IDLE and LOAD.
REQ-015 IDLE: the first transfer SHALL write the nibble to buffer[0] and go to LOAD; with wr_last it SHALL commit L=1 and go directly to SCROLL.
REQ-016 LOAD: each transfer SHALL write buffer[wr_ptr] and increment wr_ptr; a transfer with wr_last, or the DEPTH-th transfer, SHALL commit L=wr_ptr+1 and go to SCROLL on the next cycle.
REQ-017 The DEPTH-th transfer SHALL commit even when wr_last is low; no further nibble is accepted.
REQ-018 SCROLL: a tick counter SHALL count 0..TICK_DIV-1; at terminal count it SHALL wrap to 0 and offset SHALL advance by 1 modulo L.
REQ-019 HEXk (k=0..5) SHALL show the decode of buffer[(offset+5-k) mod L]; for L<6 the message repeats across the digits.
REQ-020 HEX outputs SHALL be registered and reflect a new offset or state exactly one cycle after it changes.
REQ-021 Decode SHALL use DE-series active-low patterns, e.g. 0=0x40, 1=0x79, 8=0x00, A=0x08, F=0x0E.
REQ-022 IDLE and LOAD SHALL drive all HEX to blank (0x7F).
REQ-023 SCROLL with pause high SHALL go to PAUSED; offset SHALL freeze. PAUSED with pause low SHALL return to SCROLL with the tick counter cleared to 0.
REQ-024 stop SHALL move any state to IDLE on the next edge, clearing wr_ptr, offset, counter and msg_len; the buffer contents need not be cleared.
REQ-025 stop SHALL take priority over a simultaneous transfer (the nibble is discarded) and over pause.
REQ-026 Offset SHALL be 0 at every commit, so the first displayed frame is buffer[0..5] on HEX5..HEX0.

Reset
REQ-027 RESET SHALL immediately force state=IDLE, wr_ptr=0, offset=0, counter=0, msg_len=0, HEX0..HEX5=0x7F, and wr_ready=1 once RESET deasserts.
REQ-028 Assertion of RESET mid-LOAD or mid-SCROLL SHALL discard the message exactly as stop does.

Configuration
REQ-029 With macro HEX_SCROLL_BLINK_EN defined, PAUSED SHALL keep the tick counter running and toggle all HEX between content and blank at each terminal count, starting with content on entry.
REQ-030 Without HEX_SCROLL_BLINK_EN, PAUSED SHALL freeze the counter and show frozen content continuously.

Verification (TICK_DIV=4, DEPTH=16)
REQ-031 Write 1,2,3,4,5,6,7,8 (wr_last on 8) -> state=2 next cycle, msg_len=8, HEX5..HEX0 = 0x79,0x24,0x30,0x19,0x12,0x02 one cycle later; after 4 cycles the frame shifts left one digit.
REQ-032 Scroll an 8-nibble message 8 steps -> offset wraps, and the frame equals the first frame.
REQ-033 Write 16 nibbles with wr_last low -> commit after the 16th, msg_len=16, wr_ready=0 in SCROLL.
REQ-034 Single nibble A with wr_last from IDLE -> msg_len=1, all six HEX=0x08.
REQ-035 Raise pause for 10 cycles -> state=3, frame frozen (blinks every 4 cycles if HEX_SCROLL_BLINK_EN); on release, the next shift occurs 4 cycles later.
REQ-036 stop coincident with wr_last, and separately RESET mid-SCROLL -> state=0, msg_len=0, all HEX=0x7F.
